// File: rtl/mfe_led7seg_scan_scheduler.sv
//------------------------------------------------------------------------------
// mfe_led7seg_scan_scheduler
//
// Purpose:
//   Multiplexed-refresh scheduler for an 8-digit 7-segment display that is
//   driven through a 74HC595-style shift-register serializer. The host writes
//   segment patterns into a shadow buffer. A commit copies shadow to active at
//   the next frame boundary, so a frame is never torn. The scheduler walks the
//   digits round-robin. For each digit it builds one {seg, dig_sel} word,
//   hands it to the serializer over vld/rdy, and then dwells before moving on.
//   When en drops, the current digit finishes its transfer and dwell. A blank
//   word is then shifted out and the scheduler parks in IDLE.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           scan enable
//   wr_en        host write strobe into the shadow buffer
//   wr_addr      digit index to write (indices >= DIG_NUM are ignored)
//   wr_data      segment pattern, 1 = segment on
//   commit       pulse: copy shadow to active at the next frame boundary
//   commit_pend  a commit is waiting for the frame boundary
//   frame_done   one-cycle pulse after the last digit's dwell ends
//   ser_dat      {seg[SEG_NUM-1:0], dig_sel[DIG_NUM-1:0]}, MSB shifted first
//   ser_vld      one-cycle load strobe, only ever high while ser_rdy = 1
//   ser_rdy      serializer idle
//
// Build option:
//   MFE_LED7SEG_HEX_DECODE_EN
//     Defined: wr_data[3:0] is a hex nibble that is decoded to the a..g glyph,
//     and wr_data[4] is the decimal point. The decoded pattern is stored, and
//     this mode needs SEG_NUM >= 8.
//     Undefined: wr_data is stored raw.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mfe_led7seg_scan_scheduler #(
    parameter int DIG_NUM        = 8,
    parameter int SEG_NUM        = 8,
    parameter int DWELL_CYC      = 1024,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             en,
    input  logic                                             wr_en,
    input  logic [$clog2((DIG_NUM > 1) ? DIG_NUM : 2)-1:0]   wr_addr,
    input  logic [SEG_NUM-1:0]                               wr_data,
    input  logic                                             commit,
    output logic                                             commit_pend,
    output logic                                             frame_done,
    output logic [DIG_NUM+SEG_NUM-1:0]                       ser_dat,
    output logic                                             ser_vld,
    input  logic                                             ser_rdy
);

    localparam int IDX_W  = $clog2((DIG_NUM > 1) ? DIG_NUM : 2);
    localparam int CNT_W  = $clog2(DWELL_CYC + 1);
    localparam int WORD_W = DIG_NUM + SEG_NUM;

    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIG_NUM - 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(DWELL_CYC - 1);
    // Polarity masks: XOR a raw (active-high) field with these to reach the pins.
    localparam logic [SEG_NUM-1:0] SEG_XOR  = {SEG_NUM{SEG_ACTIVE_LOW != 0}};
    localparam logic [DIG_NUM-1:0] DIG_XOR  = {DIG_NUM{DIG_ACTIVE_LOW != 0}};
    // No segment lit and no digit selected, after polarity is applied.
    localparam logic [WORD_W-1:0]  BLANK_WORD = {SEG_XOR, DIG_XOR};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCEPT,
        S_SHIFT,
        S_DWELL,
        S_BLANK
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 blank_q;        // current LOAD/ACCEPT/SHIFT pass carries the blank word
    logic                 commit_pend_q;
    logic                 frame_done_q;
    logic [WORD_W-1:0]    ser_dat_q;

    logic [SEG_NUM-1:0]   shadow_q [DIG_NUM];
    logic [SEG_NUM-1:0]   active_q [DIG_NUM];

    logic                 dwell_end;
    logic                 wrap;
    logic                 do_copy;
    logic                 load_word;
    logic [SEG_NUM-1:0]   seg_raw;
    logic [DIG_NUM-1:0]   dig_onehot;
    logic [WORD_W-1:0]    word_d;
    logic [SEG_NUM-1:0]   wr_pattern;
    logic                 wr_addr_ok;

    //--------------------------------------------------------------------------
    // Write-data formatting
    //--------------------------------------------------------------------------
`ifdef MFE_LED7SEG_HEX_DECODE_EN
    // Bits a..g are [0]..[6], and the decimal point is [7].
    function automatic logic [SEG_NUM-1:0] seg_encode(input logic [4:0] d);
        logic [6:0] glyph;
        case (d[3:0])
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
        seg_encode      = '0;
        seg_encode[6:0] = glyph;
        seg_encode[7]   = d[4];
    endfunction

    assign wr_pattern = seg_encode(wr_data[4:0]);
    // The upper data bits have no meaning in hex mode.
    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data[SEG_NUM-1:5];
`else
    assign wr_pattern = wr_data;
`endif

    // This check matters only when DIG_NUM is not a power of two.
    assign wr_addr_ok = ({1'b0, wr_addr} < (IDX_W + 1)'(DIG_NUM));

    //--------------------------------------------------------------------------
    // Shadow buffer (host side)
    //--------------------------------------------------------------------------
    // NOTE: the buffers are small flop arrays, not RAM. Clearing them in reset
    //       makes a blank display the defined power-up state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIG_NUM; i++) shadow_q[i] <= '0;
        end else if (wr_en && wr_addr_ok) begin
            shadow_q[wr_addr] <= wr_pattern;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    // NOTE: all state uses non-blocking assignments. Every flop then samples
    //       pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    // NOTE: state_d gets a default before the case. No path can leave it
    //       unassigned, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (en && ser_rdy) state_d = S_LOAD;
            // LOAD waits out a busy serializer, so vld never fires while rdy = 0.
            S_LOAD:   if (ser_rdy) state_d = S_ACCEPT;
            // The serializer drops rdy one cycle after vld. This guard cycle
            // keeps SHIFT from seeing the stale rdy.
            S_ACCEPT: state_d = S_SHIFT;
            S_SHIFT:  if (ser_rdy) state_d = blank_q ? S_IDLE : S_DWELL;
            S_DWELL:  if (cnt_q == '0) state_d = en ? S_LOAD : S_BLANK;
            S_BLANK:  if (ser_rdy) state_d = S_LOAD;
            default:  state_d = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------------
    always_comb begin
        ser_vld     = (state_q == S_LOAD) && ser_rdy;
        ser_dat     = ser_dat_q;
        frame_done  = frame_done_q;
        commit_pend = commit_pend_q;
    end

    //--------------------------------------------------------------------------
    // Datapath: index advance, commit and word build
    //--------------------------------------------------------------------------
    always_comb begin
        dwell_end = (state_q == S_DWELL) && (cnt_q == '0);
        wrap      = dwell_end && en && (idx_q == IDX_LAST);
        // A commit arriving in the boundary cycle still makes this boundary.
        do_copy   = wrap && (commit_pend_q || commit);

        idx_d = idx_q;
        if (dwell_end && en) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else if ((state_q == S_SHIFT) && ser_rdy && blank_q) begin
            idx_d = '0;
        end

        // The first word of a committed frame must already show the new
        // contents. Take it straight from shadow while active is being loaded.
        seg_raw    = do_copy ? shadow_q[idx_d] : active_q[idx_d];
        dig_onehot = DIG_NUM'(1) << idx_d;

        load_word = (state_d == S_LOAD) && (state_q != S_LOAD);
        word_d    = (state_q == S_BLANK) ? BLANK_WORD
                                         : {seg_raw ^ SEG_XOR, dig_onehot ^ DIG_XOR};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            cnt_q         <= '0;
            blank_q       <= 1'b0;
            commit_pend_q <= 1'b0;
            frame_done_q  <= 1'b0;
            ser_dat_q     <= '0;
            for (int i = 0; i < DIG_NUM; i++) active_q[i] <= '0;
        end else begin
            idx_q <= idx_d;

            if ((state_q == S_SHIFT) && ser_rdy) begin
                cnt_q <= CNT_LOAD;
            end else if ((state_q == S_DWELL) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if ((state_q == S_BLANK) && ser_rdy) begin
                blank_q <= 1'b1;
            end else if ((state_q == S_SHIFT) && ser_rdy && blank_q) begin
                blank_q <= 1'b0;
            end

            // ser_dat changes only on entry to LOAD. It then holds until the
            // next LOAD, including through IDLE.
            if (load_word) ser_dat_q <= word_d;

            frame_done_q <= wrap;

            if (do_copy) begin
                commit_pend_q <= 1'b0;
            end else if (commit) begin
                commit_pend_q <= 1'b1;
            end

            // A write in the boundary cycle reaches shadow only. The copy sees
            // the pre-edge shadow.
            if (do_copy) begin
                for (int i = 0; i < DIG_NUM; i++) active_q[i] <= shadow_q[i];
            end
        end
    end

endmodule
